reaction_ctrl: RTL
==================

Name: reaction_ctrl

Overview:
- Control and timing stage of the reaction timer. Sits directly upstream of the 4-digit LED time-mux.
- Sequences the game: greeting, random wait, stimulus LED, millisecond count, result.
- Drives active, mesg, hex3..hex0 and dp_in of the display mux.
- Start/stop/clear arrive as debounced single-cycle pulses from the button conditioning stage.

Parameters:
- TICK_DIV, 100000, clk cycles per 1 ms tick (100 MHz clock).
- DELAY_BASE_MS, 2000, minimum wait before the stimulus, in ms.
- RAND_BITS, 12, LFSR bits added to DELAY_BASE_MS (random extra 0..2^RAND_BITS-1 ms).
- MAX_MS, 1000, timeout value; must be BCD-representable, at most 9999.

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse: start a round
- stop  in  1  single-cycle pulse: user reaction
- clear  in  1  single-cycle pulse: return to greeting
- led  out  1  stimulus LED, 1 = on
- active  out  1  to display mux: 0 = all segments off
- mesg  out  1  to display mux: 1 = show "HI"
- hex3  out  4  BCD thousands digit (seconds)
- hex2  out  4  BCD hundreds digit
- hex1  out  4  BCD tens digit
- hex0  out  4  BCD ones digit (ms)
- dp_in  out  4  decimal points, active-low, bit i = digit i

Behaviour:
- Clock and reset are fixed: one clock, clk. Reset is asynchronous and active-high, port named reset.
- Reset values: state IDLE, led 0, active 1, mesg 1, hex3..hex0 all 0, dp_in 4'b1111, tick counter 0, delay counter 0. LFSR loads 16'hACE1.
- All outputs are registered. Every output takes its new value on the clock edge that changes state.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Free-runs every clk in every state except reset. Never reaches all-zero.
- Tick generator: counts 0..TICK_DIV-1 and pulses tick when it reaches TICK_DIV-1. It is cleared on every state entry, so the first tick comes TICK_DIV cycles after entry.
- Input priority when pulses coincide: clear > stop > start.
- States and transitions:
  - IDLE: active=1, mesg=1, led=0.
    - start -> WAIT. On this edge, delay counter loads DELAY_BASE_MS + LFSR[RAND_BITS-1:0].
    - stop is ignored.
  - WAIT: active=0 (blank), led=0.
    - Delay counter decrements on each tick.
    - On the tick that takes it to 0 -> TIME. On this edge: BCD count cleared to 0000, led=1.
    - stop before that tick (early press) -> DONE with hex = 9,9,9,9 and dp_in = 4'b0111 (shows "9.999").
    - start is ignored.
  - TIME: led=1, active=1, mesg=0, dp_in=4'b0111.
    - The BCD count increments once per tick and is shown live on hex3..hex0.
    - BCD increment: each digit wraps 9->0 and carries to the next digit. No binary counting, no binary-to-BCD conversion.
    - stop -> DONE. Count freezes at its current value; a tick in the same cycle is not added. led=0.
    - If the count reaches MAX_MS -> DONE holding MAX_MS (e.g. "1.000"), led=0.
  - DONE: active=1, mesg=0, led=0. Result held indefinitely. start and stop are ignored.
- clear from any state -> IDLE. hex outputs zeroed, dp_in 4'b1111, led 0.
- Reset mid-round behaves exactly like power-up reset, with no residual LED or count.
- The count never exceeds MAX_MS, and hex digits are always valid BCD (0..9).

Test Plan:
- Reset release -> active=1, mesg=1, led=0, hex=0000, dp_in=1111. No change for 1000 cycles without inputs.
- TICK_DIV=4, DELAY_BASE_MS=3, RAND_BITS=1: start -> led rises 12 or 16 cycles later (depending on LFSR bit 0). Then 4-cycle ticks. stop after 250 ticks -> hex=0,2,5,0, dp_in=0111, led=0, held.
- stop 2 cycles after start (during WAIT) -> DONE, hex=9,9,9,9, led never asserted.
- No stop in TIME with MAX_MS=1000 -> count steps ...0999 to 1000 with correct BCD carry across all digits. Then DONE, hex=1,0,0,0, led=0.
- clear and stop in the same cycle during TIME -> IDLE (mesg=1, hex=0000). start together with clear in IDLE -> stays IDLE.
- Assert reset while in TIME with led=1 -> all outputs at reset values immediately, without waiting for a clock edge. After release, a new start produces a fresh delay load.

Source files
------------

// File: rtl/reaction_ctrl.sv
// Reaction-timer sequencer: greeting, random wait, stimulus LED, BCD ms count, result hold.
// Latency: all outputs registered, one clk after the deciding input/tick; no backpressure, pulses are never stalled.
module reaction_ctrl #(
    parameter int TICK_DIV      = 100000,
    parameter int DELAY_BASE_MS = 2000,
    parameter int RAND_BITS     = 12,
    parameter int MAX_MS        = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic       led,
    output logic       active,
    output logic       mesg,
    output logic [3:0] hex3,
    output logic [3:0] hex2,
    output logic [3:0] hex1,
    output logic [3:0] hex0,
    output logic [3:0] dp_in
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DELAY_BASE_MS + (1 << RAND_BITS));
    localparam logic [15:0] MAX_BCD = {4'((MAX_MS / 1000) % 10), 4'((MAX_MS / 100) % 10),
                                       4'((MAX_MS / 10) % 10),   4'(MAX_MS % 10)};

    typedef enum logic [1:0] {IDLE, WAIT, TIME, DONE} state_t;

    state_t          state, nxt_state;
    logic [15:0]     lfsr;
    logic [TW-1:0]   tick_cnt;
    logic            tick;
    logic [DW-1:0]   delay_cnt, nxt_delay;
    logic [15:0]     count, nxt_count, inc_count;
    logic            nxt_led, nxt_active, nxt_mesg;
    logic [3:0]      nxt_dp;

    assign count = {hex3, hex2, hex1, hex0};
    assign tick  = (tick_cnt == TW'(TICK_DIV - 1));

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign inc_count = bcd_inc(count);

    always_comb begin
        nxt_state  = state;
        nxt_led    = led;
        nxt_active = active;
        nxt_mesg   = mesg;
        nxt_count  = count;
        nxt_dp     = dp_in;
        nxt_delay  = delay_cnt;
        unique case (state)
            IDLE: begin
                if (start) begin
                    nxt_state  = WAIT;
                    nxt_delay  = DW'(DELAY_BASE_MS) + DW'(lfsr[RAND_BITS-1:0]);
                    nxt_active = 1'b0;
                    nxt_mesg   = 1'b0;
                end
            end
            WAIT: begin
                if (stop) begin
                    nxt_state  = DONE;
                    nxt_count  = 16'h9999;
                    nxt_dp     = 4'b0111;
                    nxt_active = 1'b1;
                end else if (tick) begin
                    if (delay_cnt <= DW'(1)) begin
                        nxt_state  = TIME;
                        nxt_delay  = '0;
                        nxt_count  = 16'h0000;
                        nxt_led    = 1'b1;
                        nxt_active = 1'b1;
                        nxt_dp     = 4'b0111;
                    end else begin
                        nxt_delay = delay_cnt - DW'(1);
                    end
                end
            end
            TIME: begin
                // stop outranks a coincident tick, so the frozen value excludes it
                if (stop) begin
                    nxt_state = DONE;
                    nxt_led   = 1'b0;
                end else if (tick) begin
                    nxt_count = inc_count;
                    if (inc_count == MAX_BCD) begin
                        nxt_state = DONE;
                        nxt_led   = 1'b0;
                    end
                end
            end
            DONE: begin
            end
            default: nxt_state = IDLE;
        endcase
        if (clear) begin
            nxt_state  = IDLE;
            nxt_led    = 1'b0;
            nxt_active = 1'b1;
            nxt_mesg   = 1'b1;
            nxt_count  = 16'h0000;
            nxt_dp     = 4'b1111;
            nxt_delay  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                  <= IDLE;
            led                    <= 1'b0;
            active                 <= 1'b1;
            mesg                   <= 1'b1;
            {hex3, hex2, hex1, hex0} <= 16'h0000;
            dp_in                  <= 4'b1111;
            delay_cnt              <= '0;
        end else begin
            state                  <= nxt_state;
            led                    <= nxt_led;
            active                 <= nxt_active;
            mesg                   <= nxt_mesg;
            {hex3, hex2, hex1, hex0} <= nxt_count;
            dp_in                  <= nxt_dp;
            delay_cnt              <= nxt_delay;
        end
    end

    // Restarting on every state entry makes the first tick land TICK_DIV cycles in
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (nxt_state != state || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

endmodule
